// File: rtl/prewish_button_events.sv
// prewish_button_events: polls the debouncer once per tick and turns the
// debounced level into SHORT/LONG/DOUBLE event bytes, with a reply timeout.
module prewish_button_events #(
  parameter int LONG_SAMPLES = 8,
  parameter int DBL_SAMPLES  = 3,
  parameter int TIMEOUT_CLKS = 255
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_tick,
  output logic       REQ_STB_O,
  output logic [7:0] REQ_DAT_O,
  input  logic       STS_STB_I,
  input  logic [7:0] STS_DAT_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic       o_alive
);
  localparam logic [5:0]  LONG_L = 6'(LONG_SAMPLES);
  localparam logic [5:0]  DBL_L  = 6'(DBL_SAMPLES);
  localparam logic [15:0] TO_L   = 16'(TIMEOUT_CLKS - 1);
  typedef enum logic {P_IDLE, P_WAIT} p_state_t;
  typedef enum logic [2:0] {E_IDLE, E_HELD, E_GAP, E_HELD2, E_LONG} e_state_t;
  p_state_t    p_q, p_d;
  e_state_t    e_q, e_d;
  logic        tick_q, tick_rise;
  logic [15:0] wcnt_q, wcnt_d;
  logic [5:0]  dur_q, dur_d, gap_q, gap_d, nd, ng;
  logic        req_q, req_d, stb_q, stb_d, alive_q, alive_d, pressed;
  logic [7:0]  dat_q, dat_d;
  assign tick_rise = i_tick & ~tick_q;
  assign pressed   = STS_DAT_I[0];
  assign nd        = (dur_q == 6'd63) ? dur_q : dur_q + 6'd1;
  assign ng        = gap_q + 6'd1;
  // dur holds the first-press length until E_GAP leaves, then the second-press length
  always_comb begin
    p_d = p_q;
    e_d = e_q;
    wcnt_d = wcnt_q;
    dur_d = dur_q;
    gap_d = gap_q;
    req_d = 1'b0;
    stb_d = 1'b0;
    dat_d = dat_q;
    alive_d = alive_q;
    if (p_q == P_IDLE) begin
      if (tick_rise) begin
        req_d = 1'b1;
        p_d = P_WAIT;
        wcnt_d = '0;
      end
    end else if (STS_STB_I) begin
      alive_d = ~alive_q;
      p_d = P_IDLE;
      case (e_q)
        E_IDLE: if (pressed) begin
          e_d = E_HELD;
          dur_d = 6'd1;
        end
        E_HELD: if (pressed) begin
          dur_d = nd;
          if (nd == LONG_L) begin
            stb_d = 1'b1;
            dat_d = {2'b10, nd};
            e_d = E_LONG;
          end
        end else if (DBL_L == 6'd1) begin
          stb_d = 1'b1;
          dat_d = {2'b01, dur_q};
          e_d = E_IDLE;
        end else begin
          e_d = E_GAP;
          gap_d = 6'd1;
        end
        E_GAP: if (pressed) begin
          e_d = E_HELD2;
          dur_d = 6'd1;
        end else begin
          gap_d = ng;
          if (ng == DBL_L) begin
            stb_d = 1'b1;
            dat_d = {2'b01, dur_q};
            e_d = E_IDLE;
          end
        end
        E_HELD2: if (pressed) dur_d = nd;
        else begin
          stb_d = 1'b1;
          dat_d = {2'b11, dur_q};
          e_d = E_IDLE;
        end
        E_LONG: if (!pressed) e_d = E_IDLE;
        default: e_d = E_IDLE;
      endcase
    end else if (wcnt_q == TO_L) begin
      stb_d = 1'b1;
      dat_d = 8'h3F;
      p_d = P_IDLE;
    end else begin
      wcnt_d = wcnt_q + 16'd1;
    end
  end
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      p_q <= P_IDLE;
      e_q <= E_IDLE;
      tick_q <= 1'b1;
      wcnt_q <= '0;
      dur_q <= '0;
      gap_q <= '0;
      req_q <= 1'b0;
      stb_q <= 1'b0;
      dat_q <= '0;
      alive_q <= 1'b0;
    end else begin
      p_q <= p_d;
      e_q <= e_d;
      tick_q <= i_tick;
      wcnt_q <= wcnt_d;
      dur_q <= dur_d;
      gap_q <= gap_d;
      req_q <= req_d;
      stb_q <= stb_d;
      dat_q <= dat_d;
      alive_q <= alive_d;
    end
  end
  assign REQ_STB_O = req_q;
  assign REQ_DAT_O = 8'h00;
  assign STB_O     = stb_q;
  assign DAT_O     = dat_q;
  assign o_alive   = alive_q;
endmodule

// File: tb/tb_prewish_button_events.sv
// tb_prewish_button_events: randomized + directed scoreboard bench with a
// run-length gesture reference model.
module tb_prewish_button_events;
  localparam int L = 8, D = 3, T = 16;
  logic clk = 1'b0, rst_n = 1'b0, i_tick = 1'b0, sts_stb = 1'b0;
  logic [7:0] sts_dat = 8'h00;
  logic req_stb, stb;
  logic [7:0] req_dat, dat;
  logic alive;
  int vectors = 0, miscompares = 0;
  logic [7:0] exp_q[$];
  bit alive_exp = 1'b0;
  bit active = 1'b0, longed = 1'b0;
  int first = 0, gap = 0, second = 0;

  prewish_button_events #(.LONG_SAMPLES(L), .DBL_SAMPLES(D), .TIMEOUT_CLKS(T)) dut (
    .CLK_I(clk), .RST_I(rst_n), .i_tick(i_tick), .REQ_STB_O(req_stb), .REQ_DAT_O(req_dat),
    .STS_STB_I(sts_stb), .STS_DAT_I(sts_dat), .STB_O(stb), .DAT_O(dat), .o_alive(alive));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 63) ? 63 : v;
  endfunction

  // gesture classifier over run lengths: first press, release gap, second press
  task automatic model_step(input bit p);
    if (!active) begin
      if (p) begin
        active = 1; longed = 0; first = 1; gap = 0; second = 0;
      end
    end else if (longed) begin
      if (!p) active = 0;
    end else if (gap == 0) begin
      if (p) begin
        first++;
        if (first == L) begin
          exp_q.push_back({2'b10, 6'(sat(first))});
          longed = 1;
        end
      end else begin
        gap = 1;
        if (gap == D) begin
          exp_q.push_back({2'b01, 6'(sat(first))});
          active = 0;
        end
      end
    end else if (second == 0) begin
      if (p) second = 1;
      else begin
        gap++;
        if (gap == D) begin
          exp_q.push_back({2'b01, 6'(sat(first))});
          active = 0;
        end
      end
    end else if (p) second++;
    else begin
      exp_q.push_back({2'b11, 6'(sat(second))});
      active = 0;
    end
  endtask

  task automatic wait_req(output bit seen);
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      seen = req_stb;
    end
    chk("req_seen", 32'(seen), 1);
    if (seen) chk("req_dat", req_dat, 8'h00);
    i_tick = 1'b0;
  endtask

  task automatic poll(input bit p, input int k);
    bit seen;
    @(posedge clk); #1 i_tick = 1'b1;
    wait_req(seen);
    repeat (k) @(posedge clk);
    #1 sts_stb = 1'b1; sts_dat = {7'($urandom), p};
    model_step(p);
    alive_exp = ~alive_exp;
    @(posedge clk); #1 sts_stb = 1'b0;
    @(negedge clk);
    chk("alive", 32'(alive), 32'(alive_exp));
  endtask

  task automatic polls(input int n, input bit p);
    for (int i = 0; i < n; i++) poll(p, 3);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_stb", 32'(stb), 0);
    chk("rst_dat", dat, 0);
    chk("rst_alive", 32'(alive), 0);
    chk("rst_req", 32'(req_stb), 0);
    alive_exp = 0; active = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) if (rst_n && stb) begin
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected_event: got %02h expected none at %0t", dat, $time);
    end else chk("event", dat, exp_q.pop_front());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 i_tick = ~i_tick;
    end
    i_tick = 1'b1;
    @(negedge clk);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_dat", dat, 0);
    chk("rst_alive", 32'(alive), 0);
    chk("rst_req", 32'(req_stb), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_req_high_tick", 32'(req_stb), 0);
    end
    @(posedge clk); #1 i_tick = 1'b0;
    @(posedge clk); #1 i_tick = 1'b1;
    wait_req(seen);
    @(negedge clk);
    chk("req_one_cycle", 32'(req_stb), 0);
    repeat (2) @(posedge clk);
    #1 sts_stb = 1'b1; sts_dat = 8'h00; model_step(0); alive_exp = ~alive_exp;
    @(posedge clk); #1 sts_stb = 1'b0;
    // SHORT
    polls(3, 1); polls(3, 0);
    chk("short_dat", dat, 8'h43);
    // LONG then nothing more
    polls(13, 1); polls(1, 0);
    chk("long_dat", dat, 8'h88);
    // DOUBLE
    polls(2, 1); polls(1, 0); polls(3, 1); polls(1, 0);
    chk("double_dat", dat, 8'hC3);
    // timeout with no reply, then a late reply that must be ignored
    @(posedge clk); #1 i_tick = 1'b1;
    wait_req(seen);
    exp_q.push_back(8'h3F);
    repeat (T - 1) @(negedge clk);
    chk("to_early", 32'(stb), 0);
    @(negedge clk);
    chk("to_fire", 32'(stb), 1);
    @(posedge clk); #1 sts_stb = 1'b1; sts_dat = 8'h01;
    @(posedge clk); #1 sts_stb = 1'b0;
    @(negedge clk);
    chk("late_reply_alive", 32'(alive), 32'(alive_exp));
    // reply in the expiry cycle wins over the timeout
    poll(0, T - 1);
    // saturating DOUBLE duration
    polls(1, 1); polls(1, 0); polls(70, 1); polls(1, 0);
    chk("double_sat", dat, 8'hFF);
    // reset in the middle of a press
    polls(2, 1);
    do_reset();
    polls(3, 0);
    chk("post_rst_dat", dat, 8'h00);
    // randomized runs with random reply latency
    for (int r = 0; r < 60; r++) begin
      bit p = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) poll(p, $urandom_range(1, T - 2));
    end
    polls(D + 1, 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
